elink_rx_deframer: RTL and testbench
====================================

// Module: elink_rx_deframer
// PURPOSE
//  Receive-side protocol engine of the eLink: consumes the byte-wide, frame-delimited stream driven by a
//  remote eLink transmitter (post-IBUFDS/IDDR, one byte per rxi_lclk), rebuilds 104-bit emesh packets,
//  buffers them and drives rxo_wr_wait/rxo_rd_wait back-pressure. Sits between the rxi pins and the emesh/AXI master.
// PARAMETERS
//  PW          104  emesh packet width {srcaddr[31:0],data[31:0],dstaddr[31:0],ctrlmode[3:0],datamode[1:0],write,access}
//  FIFO_DEPTH  16   packet FIFO entries (power of 2)
//  WAIT_MARGIN 6    wait asserted when occupancy >= FIFO_DEPTH-WAIT_MARGIN (covers remote reaction latency)
// PORTS
//  rxi_lclk       in   1    link clock; only clock
//  hard_reset     in   1    asynchronous, active-high reset
//  rxi_data       in   8    link byte
//  rxi_frame      in   1    frame qualifier; rising edge marks byte 0
//  rxo_wr_wait    out  1    write back-pressure to remote
//  rxo_rd_wait    out  1    read back-pressure to remote
//  emesh_access   out  1    packet valid
//  emesh_packet   out  PW   packet, stable while emesh_access & emesh_wait
//  emesh_wait     in   1    downstream stall
//  err_trunc      out  1    1-cycle pulse: frame dropped mid-packet
//  err_overflow   out  1    1-cycle pulse: packet lost, FIFO full
// BEHAVIOUR
//  Byte map: B0 header (ignored); B1={ctrlmode,dstaddr[31:28]}; B2..B4=dstaddr[27:4]; B5={dstaddr[3:0],datamode,write,access};
//   B6..B9=data MSB first; B10..B13=srcaddr MSB first. Byte index counter 0..13, 4 bits.
//  FSM: IDLE -> HDR (B1-B5) -> DATA (B6-B9) -> SRC (B10-B13) -> IDLE | DATA | DRAIN.
//   IDLE->HDR on cycle rxi_frame=1 & frame_q=0 (that byte is B0). frame_q resets to 1: a frame already high at
//   reset release is ignored until frame is seen low.
//  Completion: on the edge sampling B13, packet is pushed. If rxi_frame still 1 on the next byte:
//   write=1 -> burst: DATA again, dstaddr += 8 (mod 2^32), ctrlmode/datamode/write/access retained;
//   write=0 -> DRAIN, bytes discarded until rxi_frame=0, no error.
//  rxi_frame=0 in HDR/DATA/SRC: partial discarded, err_trunc pulses next cycle, -> IDLE. A frame low in the cycle after B13 is a clean end.
//  FIFO: first-word-fall-through; emesh_access rises 1 cycle after the B13 edge when FIFO empty. Pop = emesh_access & ~emesh_wait.
//   Push when full without pop: packet dropped, err_overflow pulses. Push+pop in same cycle while full: accepted.
//  Wait: rxo_wr_wait = rxo_rd_wait = registered (count >= FIFO_DEPTH-WAIT_MARGIN); update 1 cycle after count change.
//  Reset (async, any cycle incl. mid-packet): FSM IDLE, FIFO emptied, partial packet lost; emesh_access=0, emesh_packet=0,
//   err_*=0, rxo_wr_wait=rxo_rd_wait=1 while hard_reset is high, 0 on the first edge after release.
// STRUCTURE
//  elink_pkg: PW, byte-index localparams (B_CTRL=1, B_MODE=5, B_DATA0=6, B_SRC0=10, B_LAST=13), rx FSM state enum.
//  Sub-module elink_rx_pkt_fifo (PW wide, FIFO_DEPTH deep, FWFT, count output); deframer FSM + assembly regs in top.
// TESTING
//  1 write: frame high 14 bytes, dst=0x80800010 data=0xDEADBEEF src=0x00000040 write=1 -> one packet, fields exact, access 1 cycle after B13.
//  2 burst: 14+8+8 bytes, frame held -> 3 packets, dstaddr 0x80800010/18/20, data/src per beat.
//  3 truncation: frame drops after B7 -> err_trunc one pulse, no packet; next full frame decoded correctly.
//  4 back-pressure: emesh_wait=1, stream 10 packets -> rxo_wr_wait rises once count=10, packet held stable; release -> 10 packets in order.
//  5 overflow: emesh_wait=1, ignore wait, send 17 packets -> 16 stored, err_overflow pulses once, 17th lost.
//  6 reset mid-SRC with frame held high -> no packet; wait=1 during reset; bytes ignored until frame low, then next frame decoded.

Source files
------------

// File: rtl/elink_pkg.sv
// Shared definitions for the eLink receive path: packet layout, frame byte
// positions and the deframer state encoding.
package elink_pkg;

    localparam int PW = 104;

    localparam logic [3:0] B_CTRL  = 4'd1;
    localparam logic [3:0] B_MODE  = 4'd5;
    localparam logic [3:0] B_DATA0 = 4'd6;
    localparam logic [3:0] B_SRC0  = 4'd10;
    localparam logic [3:0] B_LAST  = 4'd13;

    // Burst beats advance the destination by one doubleword.
    localparam logic [31:0] BURST_STRIDE = 32'd8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HDR,
        RX_DATA,
        RX_SRC,
        RX_DRAIN
    } rx_state_t;

    typedef struct packed {
        logic [31:0] srcaddr;
        logic [31:0] data;
        logic [31:0] dstaddr;
        logic [3:0]  ctrlmode;
        logic [1:0]  datamode;
        logic        write;
        logic        access;
    } emesh_pkt_t;

    function automatic emesh_pkt_t make_pkt(
        input logic [31:0] srcaddr,
        input logic [31:0] data,
        input logic [31:0] dstaddr,
        input logic [3:0]  ctrlmode,
        input logic [1:0]  datamode,
        input logic        write,
        input logic        access
    );
        emesh_pkt_t p;
        p.srcaddr  = srcaddr;
        p.data     = data;
        p.dstaddr  = dstaddr;
        p.ctrlmode = ctrlmode;
        p.datamode = datamode;
        p.write    = write;
        p.access   = access;
        return p;
    endfunction

endpackage

// File: rtl/elink_rx_pkt_fifo.sv
// First-word-fall-through packet FIFO with occupancy count; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module elink_rx_pkt_fifo #(
    parameter int W     = 104,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        overflow = push && !do_push;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/elink_rx_deframer.sv
// eLink receive deframer: rebuilds emesh packets from the framed byte stream,
// handles write bursts, buffers packets and raises back-pressure to the remote.
module elink_rx_deframer #(
    parameter int PW          = elink_pkg::PW,
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_MARGIN = 6
) (
    input  logic          rxi_lclk,
    input  logic          hard_reset,
    input  logic [7:0]    rxi_data,
    input  logic          rxi_frame,
    output logic          rxo_wr_wait,
    output logic          rxo_rd_wait,
    output logic          emesh_access,
    output logic [PW-1:0] emesh_packet,
    input  logic          emesh_wait,
    output logic          err_trunc,
    output logic          err_overflow
);

    import elink_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - WAIT_MARGIN);

    rx_state_t   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        frame_q, frame_d;
    logic        beat_done_q, beat_done_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] dst_q, dst_d;
    logic [1:0]  mode_q, mode_d;
    logic        write_q, write_d;
    logic        access_q, access_d;
    logic [31:0] data_q, data_d;
    logic [31:0] src_q, src_d;
    emesh_pkt_t  pkt_q, pkt_d;
    logic        push_q, push_d;
    logic        trunc_q, trunc_d;
    logic        ovf_q, ovf_d;
    logic        wait_q, wait_d;

    logic [PW-1:0] fifo_head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_ovf;
    logic          fifo_pop;

    assign fifo_pop = !fifo_empty && !emesh_wait;

    elink_rx_pkt_fifo #(
        .W     (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rxi_lclk),
        .rst       (hard_reset),
        .push      (push_q),
        .push_data (PW'(pkt_q)),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_d     = rxi_frame;
        beat_done_d = 1'b0;
        ctrl_d      = ctrl_q;
        dst_d       = dst_q;
        mode_d      = mode_q;
        write_d     = write_q;
        access_d    = access_q;
        data_d      = data_q;
        src_d       = src_q;
        pkt_d       = pkt_q;
        push_d      = 1'b0;
        trunc_d     = 1'b0;
        ovf_d       = fifo_ovf;
        wait_d      = (fifo_count >= WAIT_LEVEL);

        case (state_q)
            RX_IDLE: begin
                // Only a low-to-high frame transition starts a packet; this byte is B0.
                if (rxi_frame && !frame_q) begin
                    state_d = RX_HDR;
                    idx_d   = B_CTRL;
                end
            end
            RX_DRAIN: begin
                if (!rxi_frame) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                if (!rxi_frame) begin
                    // Frame low right after B13 is a clean end, anywhere else a truncation.
                    state_d = RX_IDLE;
                    trunc_d = !beat_done_q;
                end else if (beat_done_q && !write_q) begin
                    state_d = RX_DRAIN;
                end else begin
                    if (beat_done_q) begin
                        dst_d = dst_q + BURST_STRIDE;
                    end
                    if (idx_q == B_CTRL) begin
                        ctrl_d        = rxi_data[7:4];
                        dst_d[31:28]  = rxi_data[3:0];
                    end else if (idx_q == B_CTRL + 4'd1) begin
                        dst_d[27:20]  = rxi_data;
                    end else if (idx_q == B_CTRL + 4'd2) begin
                        dst_d[19:12]  = rxi_data;
                    end else if (idx_q == B_CTRL + 4'd3) begin
                        dst_d[11:4]   = rxi_data;
                    end else if (idx_q == B_MODE) begin
                        dst_d[3:0]    = rxi_data[7:4];
                        mode_d        = rxi_data[3:2];
                        write_d       = rxi_data[1];
                        access_d      = rxi_data[0];
                        state_d       = RX_DATA;
                    end else if (idx_q < B_SRC0) begin
                        data_d = {data_q[23:0], rxi_data};
                        if (idx_q == B_SRC0 - 4'd1) begin
                            state_d = RX_SRC;
                        end
                    end else begin
                        src_d = {src_q[23:0], rxi_data};
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == B_LAST) begin
                        push_d      = 1'b1;
                        beat_done_d = 1'b1;
                        idx_d       = B_DATA0;
                        state_d     = RX_DATA;
                        pkt_d       = make_pkt({src_q[23:0], rxi_data}, data_q, dst_q,
                                               ctrl_q, mode_q, write_q, access_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge rxi_lclk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q     <= RX_IDLE;
            idx_q       <= '0;
            frame_q     <= 1'b1;
            beat_done_q <= 1'b0;
            ctrl_q      <= '0;
            dst_q       <= '0;
            mode_q      <= '0;
            write_q     <= 1'b0;
            access_q    <= 1'b0;
            data_q      <= '0;
            src_q       <= '0;
            pkt_q       <= '0;
            push_q      <= 1'b0;
            trunc_q     <= 1'b0;
            ovf_q       <= 1'b0;
            wait_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            beat_done_q <= beat_done_d;
            ctrl_q      <= ctrl_d;
            dst_q       <= dst_d;
            mode_q      <= mode_d;
            write_q     <= write_d;
            access_q    <= access_d;
            data_q      <= data_d;
            src_q       <= src_d;
            pkt_q       <= pkt_d;
            push_q      <= push_d;
            trunc_q     <= trunc_d;
            ovf_q       <= ovf_d;
            wait_q      <= wait_d;
        end
    end

    assign rxo_wr_wait  = wait_q;
    assign rxo_rd_wait  = wait_q;
    assign emesh_access = !fifo_empty;
    assign emesh_packet = fifo_head;
    assign err_trunc    = trunc_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_elink_rx_deframer.sv
// Directed bench for the eLink receive deframer: single packets, bursts,
// truncation, back-pressure, overflow and reset in mid-packet.
module tb_elink_rx_deframer;

    import elink_pkg::*;

    logic         rxi_lclk;
    logic         hard_reset;
    logic [7:0]   rxi_data;
    logic         rxi_frame;
    logic         rxo_wr_wait;
    logic         rxo_rd_wait;
    logic         emesh_access;
    logic [103:0] emesh_packet;
    logic         emesh_wait;
    logic         err_trunc;
    logic         err_overflow;

    int checks = 0;
    int errors = 0;
    int trunc_pulses = 0;
    int ovf_pulses = 0;

    elink_rx_deframer dut (
        .rxi_lclk     (rxi_lclk),
        .hard_reset   (hard_reset),
        .rxi_data     (rxi_data),
        .rxi_frame    (rxi_frame),
        .rxo_wr_wait  (rxo_wr_wait),
        .rxo_rd_wait  (rxo_rd_wait),
        .emesh_access (emesh_access),
        .emesh_packet (emesh_packet),
        .emesh_wait   (emesh_wait),
        .err_trunc    (err_trunc),
        .err_overflow (err_overflow)
    );

    initial rxi_lclk = 1'b0;
    always #5 rxi_lclk = ~rxi_lclk;

    always @(negedge rxi_lclk) begin
        if (err_trunc === 1'b1) trunc_pulses++;
        if (err_overflow === 1'b1) ovf_pulses++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic byte_step(input logic f, input logic [7:0] d);
        rxi_frame = f;
        rxi_data  = d;
        @(posedge rxi_lclk);
        #1;
    endtask

    task automatic send_hdr(input logic [31:0] dst, input logic [3:0] ctrl,
                            input logic [1:0] dm, input logic w);
        byte_step(1'b1, 8'hA5);
        byte_step(1'b1, {ctrl, dst[31:28]});
        byte_step(1'b1, dst[27:20]);
        byte_step(1'b1, dst[19:12]);
        byte_step(1'b1, dst[11:4]);
        byte_step(1'b1, {dst[3:0], dm, w, 1'b1});
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [31:0] src);
        byte_step(1'b1, data[31:24]);
        byte_step(1'b1, data[23:16]);
        byte_step(1'b1, data[15:8]);
        byte_step(1'b1, data[7:0]);
        byte_step(1'b1, src[31:24]);
        byte_step(1'b1, src[23:16]);
        byte_step(1'b1, src[15:8]);
        byte_step(1'b1, src[7:0]);
    endtask

    task automatic send_single(input logic [31:0] dst, input logic [31:0] data,
                               input logic [31:0] src, input logic [3:0] ctrl,
                               input logic [1:0] dm, input logic w);
        send_hdr(dst, ctrl, dm, w);
        send_beat(data, src);
        byte_step(1'b0, 8'h00);
    endtask

    task automatic pop_check(input string tag, input logic [103:0] expv);
        chk({tag, "_access"}, {127'd0, emesh_access}, 128'd1);
        chk({tag, "_pkt"}, {24'd0, emesh_packet}, {24'd0, expv});
        emesh_wait = 1'b0;
        byte_step(1'b0, 8'h00);
        emesh_wait = 1'b1;
    endtask

    function automatic logic [103:0] mk(input logic [31:0] src, input logic [31:0] data,
                                        input logic [31:0] dst, input logic [3:0] ctrl,
                                        input logic [1:0] dm, input logic w);
        return {src, data, dst, ctrl, dm, w, 1'b1};
    endfunction

    initial begin
        hard_reset = 1'b1;
        rxi_frame  = 1'b0;
        rxi_data   = 8'h00;
        emesh_wait = 1'b1;
        #1;
        chk("rst_wr_wait", {127'd0, rxo_wr_wait}, 128'd1);
        chk("rst_rd_wait", {127'd0, rxo_rd_wait}, 128'd1);
        chk("rst_access", {127'd0, emesh_access}, 128'd0);
        chk("rst_packet", {24'd0, emesh_packet}, 128'd0);
        chk("rst_errs", {126'd0, err_trunc, err_overflow}, 128'd0);
        @(posedge rxi_lclk);
        @(posedge rxi_lclk);
        #3 hard_reset = 1'b0;
        byte_step(1'b0, 8'h00);
        chk("rel_wait", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd0);

        // 1: single write, access one cycle after the B13 edge
        emesh_wait = 1'b0;
        send_hdr(32'h80800010, 4'h0, 2'b10, 1'b1);
        send_beat(32'hDEADBEEF, 32'h00000040);
        chk("t1_access_b13", {127'd0, emesh_access}, 128'd0);
        byte_step(1'b0, 8'h00);
        chk("t1_access", {127'd0, emesh_access}, 128'd1);
        chk("t1_pkt", {24'd0, emesh_packet},
            {24'd0, 32'h00000040, 32'hDEADBEEF, 32'h80800010, 4'h0, 2'b10, 1'b1, 1'b1});
        chk("t1_no_trunc", {127'd0, err_trunc}, 128'd0);
        byte_step(1'b0, 8'h00);
        chk("t1_popped", {127'd0, emesh_access}, 128'd0);

        // 2: three-beat write burst
        emesh_wait = 1'b1;
        trunc_pulses = 0;
        send_hdr(32'h80800010, 4'h0, 2'b10, 1'b1);
        send_beat(32'h11111111, 32'h000000A0);
        send_beat(32'h22222222, 32'h000000A4);
        send_beat(32'h33333333, 32'h000000A8);
        byte_step(1'b0, 8'h00);
        byte_step(1'b0, 8'h00);
        pop_check("t2_b0", mk(32'h000000A0, 32'h11111111, 32'h80800010, 4'h0, 2'b10, 1'b1));
        pop_check("t2_b1", mk(32'h000000A4, 32'h22222222, 32'h80800018, 4'h0, 2'b10, 1'b1));
        pop_check("t2_b2", mk(32'h000000A8, 32'h33333333, 32'h80800020, 4'h0, 2'b10, 1'b1));
        chk("t2_empty", {127'd0, emesh_access}, 128'd0);
        chk("t2_no_trunc", trunc_pulses, 0);

        // 3: truncation after B7, then a clean read packet
        send_hdr(32'h44440000, 4'h0, 2'b10, 1'b1);
        byte_step(1'b1, 8'h01);
        byte_step(1'b1, 8'h02);
        byte_step(1'b0, 8'h00);
        chk("t3_trunc_hi", {127'd0, err_trunc}, 128'd1);
        byte_step(1'b0, 8'h00);
        chk("t3_trunc_lo", {127'd0, err_trunc}, 128'd0);
        chk("t3_no_pkt", {127'd0, emesh_access}, 128'd0);
        send_single(32'h00001234, 32'h0BADF00D, 32'h12345678, 4'h3, 2'b01, 1'b0);
        pop_check("t3_next",
            {32'h12345678, 32'h0BADF00D, 32'h00001234, 4'h3, 2'b01, 1'b0, 1'b1});
        chk("t3_trunc_count", trunc_pulses, 1);

        // 4: back-pressure with ten buffered packets
        for (int i = 0; i < 10; i++) begin
            send_single(32'h00001000 + 32'(i * 16), 32'hC0DE0000 + 32'(i),
                        32'h50000000 + 32'(i), 4'h1, 2'b10, 1'b1);
            if (i == 8) chk("t4_wait_9", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd0);
        end
        chk("t4_wait_lag", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd0);
        byte_step(1'b0, 8'h00);
        chk("t4_wait_10", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd3);
        byte_step(1'b0, 8'h00);
        chk("t4_held", {24'd0, emesh_packet},
            {24'd0, mk(32'h50000000, 32'hC0DE0000, 32'h00001000, 4'h1, 2'b10, 1'b1)});
        for (int i = 0; i < 10; i++) begin
            pop_check($sformatf("t4_pop%0d", i),
                mk(32'h50000000 + 32'(i), 32'hC0DE0000 + 32'(i),
                   32'h00001000 + 32'(i * 16), 4'h1, 2'b10, 1'b1));
        end
        byte_step(1'b0, 8'h00);
        chk("t4_wait_clr", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd0);

        // 5: overflow on the 17th packet
        ovf_pulses = 0;
        for (int i = 0; i < 17; i++) begin
            send_single(32'h00002000 + 32'(i * 16), 32'hF0000000 + 32'(i),
                        32'h60000000 + 32'(i), 4'h0, 2'b10, 1'b1);
        end
        chk("t5_ovf_hi", {127'd0, err_overflow}, 128'd1);
        byte_step(1'b0, 8'h00);
        chk("t5_ovf_lo", {127'd0, err_overflow}, 128'd0);
        chk("t5_ovf_count", ovf_pulses, 1);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("t5_pop%0d", i),
                mk(32'h60000000 + 32'(i), 32'hF0000000 + 32'(i),
                   32'h00002000 + 32'(i * 16), 4'h0, 2'b10, 1'b1));
        end
        chk("t5_lost", {127'd0, emesh_access}, 128'd0);

        // 6: reset in the middle of SRC with frame held high
        emesh_wait = 1'b0;
        trunc_pulses = 0;
        send_hdr(32'h22220000, 4'h2, 2'b00, 1'b1);
        byte_step(1'b1, 8'h01);
        byte_step(1'b1, 8'h02);
        byte_step(1'b1, 8'h03);
        byte_step(1'b1, 8'h04);
        byte_step(1'b1, 8'h05);
        byte_step(1'b1, 8'h06);
        #2 hard_reset = 1'b1;
        #1;
        chk("t6_rst_wait", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd3);
        chk("t6_rst_access", {127'd0, emesh_access}, 128'd0);
        byte_step(1'b1, 8'h07);
        chk("t6_rst_wait2", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd3);
        #3 hard_reset = 1'b0;
        byte_step(1'b1, 8'h08);
        chk("t6_rel_wait", {126'd0, rxo_wr_wait, rxo_rd_wait}, 128'd0);
        for (int i = 0; i < 16; i++) begin
            byte_step(1'b1, 8'h10 + 8'(i));
        end
        chk("t6_ignored", {127'd0, emesh_access}, 128'd0);
        chk("t6_no_trunc", trunc_pulses, 0);
        byte_step(1'b0, 8'h00);
        emesh_wait = 1'b1;
        send_single(32'h33330008, 32'h600DCAFE, 32'h00000ABC, 4'h0, 2'b10, 1'b0);
        pop_check("t6_next",
            {32'h00000ABC, 32'h600DCAFE, 32'h33330008, 4'h0, 2'b10, 1'b0, 1'b1});
        chk("t6_empty", {127'd0, emesh_access}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
